// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: bit-reversed to natural-order reorder buffer for a streaming FFT.
// Two ping-pong banks of N = 2**TOTAL_STAGE {real,imag} words. The writer stores each sample
// at its tagged bin index. The reader replays a full bank as bins 0..N-1 on a valid/ready
// stream through a 1-cycle synchronous RAM read and a 2-entry skid.
// Optional build macro FFT_REORDER_DROP_CNT_EN adds odrop_cnt, a saturating count of
// dropped frames.
`default_nettype none

module fft_reorder_buf #(
    parameter int REAL_WIDTH  = 18,
    parameter int IMGN_WIDTH  = 18,
    parameter int TOTAL_STAGE = 11
) (
    input  logic                   iclk,
    input  logic                   rst,
    input  logic                   ien,
    input  logic [TOTAL_STAGE-1:0] iaddr,
    input  logic [REAL_WIDTH-1:0]  iReal,
    input  logic [IMGN_WIDTH-1:0]  iImag,
    output logic                   ovalid,
    input  logic                   ordy,
    output logic [TOTAL_STAGE-1:0] oaddr,
    output logic [REAL_WIDTH-1:0]  oReal,
    output logic [IMGN_WIDTH-1:0]  oImag,
    output logic                   olast,
    output logic                   ovf
`ifdef FFT_REORDER_DROP_CNT_EN
    ,
    output logic [15:0]            odrop_cnt
`endif
);

    localparam int                   N        = 1 << TOTAL_STAGE;
    localparam int                   DW       = REAL_WIDTH + IMGN_WIDTH;
    localparam logic [TOTAL_STAGE-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_t;

`ifdef FFT_REORDER_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // Frame storage: bank select is the top address bit
    logic [DW-1:0] mem [0:2*N-1];

    bank_state_t bank_st  [2];
    bank_state_t bank_nxt [2];

    // Writer control
    logic                   wr_bank;
    logic [TOTAL_STAGE-1:0] wr_cnt;
    logic                   dropping;
    logic                   wr_start;
    logic                   tgt_free;
    logic                   wr_accept;
    logic                   wr_drop_start;
    logic                   wr_en;
    logic                   wr_done;

    // Reader issue stage (p0)
    logic                   rd_busy;
    logic                   rd_bank_p0;
    logic [TOTAL_STAGE-1:0] rd_addr_p0;
    logic                   rd_go;
    logic                   vld_p0;
    logic                   rd_first;

    // RAM output register (p1)
    logic                   vld_p1;
    logic [DW-1:0]          data_p1;
    logic [TOTAL_STAGE-1:0] addr_p1;
    logic                   last_p1;
    logic                   bank_p1;

    // Skid entry (p2)
    logic                   vld_p2;
    logic [DW-1:0]          data_p2;
    logic [TOTAL_STAGE-1:0] addr_p2;
    logic                   last_p2;
    logic                   bank_p2;

    // Output view
    logic [DW-1:0]          out_data;
    logic [TOTAL_STAGE-1:0] out_addr;
    logic                   out_last;
    logic                   out_bank;
    logic                   xfer;
    logic [1:0]             free_vec;

    // ---- output selection: skid entry has priority over the RAM register ----
    assign out_data = vld_p2 ? data_p2 : data_p1;
    assign out_addr = vld_p2 ? addr_p2 : addr_p1;
    assign out_last = vld_p2 ? last_p2 : last_p1;
    assign out_bank = vld_p2 ? bank_p2 : bank_p1;

    assign ovalid = vld_p2 | vld_p1;
    assign xfer   = ovalid & ordy;
    assign oaddr  = ovalid ? out_addr : '0;
    assign oReal  = ovalid ? out_data[DW-1:IMGN_WIDTH] : '0;
    assign oImag  = ovalid ? out_data[IMGN_WIDTH-1:0] : '0;
    assign olast  = ovalid & out_last;

    // Transfer of bin N-1 releases the bank it came from
    assign free_vec[0] = xfer & out_last & ~out_bank;
    assign free_vec[1] = xfer & out_last & out_bank;

    // ---- write side ----
    // A bank freeing this very cycle counts as empty, so a new frame can reuse it at once
    assign wr_start      = ien && (wr_cnt == '0);
    assign tgt_free      = (bank_st[wr_bank] == B_EMPTY) ||
                           ((bank_st[wr_bank] == B_DRAINING) && free_vec[wr_bank]);
    assign wr_accept     = wr_start && tgt_free;
    assign wr_drop_start = wr_start && !tgt_free;
    assign wr_en         = wr_accept || (ien && (wr_cnt != '0) && !dropping);
    assign wr_done       = wr_en && (wr_cnt == LAST_IDX);

    // Writer counter, frame drop flag, write bank pointer and sticky overflow
    always_ff @(posedge iclk) begin
        if (rst) begin
            wr_cnt   <= '0;
            dropping <= 1'b0;
            wr_bank  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            // Counter runs for every strobe, accepted or dropped, to keep frame alignment
            if (ien)
                wr_cnt <= wr_cnt + 1'b1;
            if (wr_start)
                dropping <= !tgt_free;
            // Frames always alternate banks so the reader can follow a simple toggle;
            // if the other bank is still busy the next frame start drops and retries.
            if (wr_done)
                wr_bank <= ~wr_bank;
            if (wr_drop_start)
                ovf <= 1'b1;
        end
    end

`ifdef FFT_REORDER_DROP_CNT_EN
    // Saturating count of dropped frames
    always_ff @(posedge iclk) begin
        if (rst)
            odrop_cnt <= 16'd0;
        else if (wr_drop_start)
            odrop_cnt <= sat_inc16(odrop_cnt);
    end
`endif

    // Sample store at the natural-order bin index
    always_ff @(posedge iclk) begin
        if (wr_en)
            mem[{wr_bank, iaddr}] <= {iReal, iImag};
    end

    // ---- bank state machines ----
    // Next state per bank; a free and a new-frame start on the same bank resolve to FILLING
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nxt[b] = bank_st[b];
            if (free_vec[b])
                bank_nxt[b] = B_EMPTY;
            if (wr_accept && (wr_bank == 1'(b)))
                bank_nxt[b] = B_FILLING;
            if (wr_done && (wr_bank == 1'(b)))
                bank_nxt[b] = B_FULL;
            if (rd_first && (rd_bank_p0 == 1'(b)))
                bank_nxt[b] = B_DRAINING;
        end
    end

    // Bank state registers
    always_ff @(posedge iclk) begin
        if (rst) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
        end else begin
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];
        end
    end

    // ---- p0: read issue ----
    // Start reading the moment the pointed bank is FULL; issue only while the skid is empty,
    // which keeps at most two bins in flight without a combinational path from ordy.
    assign rd_go    = rd_busy || (bank_st[rd_bank_p0] == B_FULL);
    assign vld_p0   = rd_go && !vld_p2;
    assign rd_first = vld_p0 && !rd_busy;

    // Read address counter and reader bank pointer
    always_ff @(posedge iclk) begin
        if (rst) begin
            rd_busy    <= 1'b0;
            rd_bank_p0 <= 1'b0;
            rd_addr_p0 <= '0;
        end else if (vld_p0) begin
            rd_addr_p0 <= rd_addr_p0 + 1'b1;
            if (rd_addr_p0 == LAST_IDX) begin
                rd_busy    <= 1'b0;
                rd_bank_p0 <= ~rd_bank_p0;
            end else begin
                rd_busy <= 1'b1;
            end
        end
    end

    // ---- p1: synchronous RAM read ----
    // RAM output register holds its word until the next issue
    always_ff @(posedge iclk) begin
        if (vld_p0) begin
            data_p1 <= mem[{rd_bank_p0, rd_addr_p0}];
            addr_p1 <= rd_addr_p0;
            last_p1 <= (rd_addr_p0 == LAST_IDX);
            bank_p1 <= rd_bank_p0;
        end
    end

    // ---- p2: skid entry ----
    // Capture the RAM word into the skid whenever the skid is empty; it only becomes valid
    // when the RAM word was presented but not accepted.
    always_ff @(posedge iclk) begin
        if (!vld_p2) begin
            data_p2 <= data_p1;
            addr_p2 <= addr_p1;
            last_p2 <= last_p1;
            bank_p2 <= bank_p1;
        end
    end

    // Valid flags of the RAM register and the skid entry
    always_ff @(posedge iclk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!vld_p2) begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1 && !ordy;
        end else begin
            vld_p2 <= !ordy;
        end
    end

endmodule

`default_nettype wire
